// File: rtl/seq2par_packer_pkg.sv
// Shared accelerator-path definitions: default sample geometry, clog2 helper
// and the lane-index type used by the packer.
package accel_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int LANES_DEF  = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   typedef logic [clog2(LANES_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/seq2par_packer_if.sv
// Serial input stream, packed output stream and prefetch request of the packer.
interface seq2par_packer_if
   import accel_pkg::*;
   #(parameter int DATA_W = DATA_W_DEF,
     parameter int LANES  = LANES_DEF);

   logic [DATA_W-1:0]       in_data;
   logic                    in_valid;
   logic                    in_last;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] out_data;
   logic [LANES-1:0]        out_keep;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready;
   logic                    read_req;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_keep, out_last, out_valid, read_req
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_keep, out_last, out_valid, read_req
   );

endinterface

// File: rtl/seq2par_out_stage.sv
// Output holding register: captures a finished word and holds it stable
// until the consumer takes it; a new load on the transfer edge keeps full rate.
module seq2par_out_stage #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [LANES*DATA_W-1:0] load_data,
   input  logic [LANES-1:0]        load_keep,
   input  logic                    load_last,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_keep,
   output logic                    out_last,
   output logic                    out_valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= load_data;
         out_keep  <= load_keep;
         out_last  <= load_last;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/seq2par_packer.sv
// Serial-to-parallel packer: oldest sample lands in the MSB lane, partial
// words flush left-aligned on in_last, read_req pulses after sample REQ_AT.
module seq2par_packer
   import accel_pkg::*;
   #(parameter int                 DATA_W  = DATA_W_DEF,
     parameter int                 LANES   = LANES_DEF,
     parameter int                 REQ_AT  = 2,
     parameter logic [DATA_W-1:0]  PAD_VAL = '0)
   (
   input  logic            clk,
   input  logic            rst_n,
   seq2par_packer_if.slave bus
);

   localparam int CW = clog2(LANES);

   generate
      if (LANES < 2 || REQ_AT < 1 || REQ_AT > LANES) begin : g_bad_param
         $error("seq2par_packer: need LANES >= 2 and 1 <= REQ_AT <= LANES");
      end
   endgenerate

   // Only LANES-1 samples are ever held; the closing sample comes straight from in_data.
   logic [(LANES-1)*DATA_W-1:0] sreg;
   logic [CW-1:0]               count;
   logic                        accept;
   logic                        close;
   logic [LANES*DATA_W-1:0]     nxt;
   logic [LANES*DATA_W-1:0]     ld_data;
   logic [LANES-1:0]            ld_keep;
   int                          shift;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign close        = accept && (bus.in_last || count == CW'(LANES-1));

   // Left-align the count+1 newest samples; lanes below them get PAD_VAL.
   always_comb begin
      nxt     = {sreg, bus.in_data};
      shift   = LANES - 1 - int'(count);
      ld_data = '0;
      ld_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i >= shift) begin
            ld_data[i*DATA_W +: DATA_W] = nxt[(i-shift)*DATA_W +: DATA_W];
            ld_keep[i]                  = 1'b1;
         end else begin
            ld_data[i*DATA_W +: DATA_W] = PAD_VAL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg         <= '0;
         count        <= '0;
         bus.read_req <= 1'b0;
      end else begin
         bus.read_req <= accept && (count == CW'(REQ_AT-1));
         if (close) begin
            sreg  <= '0;
            count <= '0;
         end else if (accept) begin
            sreg  <= nxt[(LANES-1)*DATA_W-1:0];
            count <= count + CW'(1);
         end
      end
   end

   seq2par_out_stage #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_out_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (close),
      .load_data (ld_data),
      .load_keep (ld_keep),
      .load_last (bus.in_last),
      .out_ready (bus.out_ready),
      .out_data  (bus.out_data),
      .out_keep  (bus.out_keep),
      .out_last  (bus.out_last),
      .out_valid (bus.out_valid)
   );

endmodule

// File: tb/tb_seq2par_packer.sv
// Scoreboard bench for seq2par_packer: directed samples push hand-computed
// words and read_req cycles; a negedge monitor pops and compares.
module tb_seq2par_packer;
   import accel_pkg::*;

   localparam int DW = 8;
   localparam int LN = 4;
   localparam int RQ = 2;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          cyc;
   } word_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq2par_packer_if #(.DATA_W(DW), .LANES(LN)) bus();

   seq2par_packer #(
      .DATA_W  (DW),
      .LANES   (LN),
      .REQ_AT  (RQ),
      .PAD_VAL (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   word_t exp_q[$];
   int    rr_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    tb_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      word_t w;
      int    c;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h required none", bus.out_data);
         end else begin
            w = exp_q.pop_front();
            chk("out_data", bus.out_data, w.data);
            chk("out_keep", 32'(bus.out_keep), 32'(w.keep));
            chk("out_last", 32'(bus.out_last), 32'(w.last));
            if (w.cyc >= 0) chk("out_latency_cycle", cyc, w.cyc);
         end
      end
      if (rst_n && bus.read_req) begin
         if (rr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read_req: got pulse at cycle %0d required none", cyc);
         end else begin
            c = rr_q.pop_front();
            chk("read_req_cycle", cyc, c);
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last, output int acc);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      acc = -1;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (ok) begin
         acc = cyc;
         if (tb_cnt + 1 == RQ) rr_q.push_back(acc);
         tb_cnt = (last || tb_cnt + 1 == LN) ? 0 : tb_cnt + 1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic last, input bit timed);
      int acc;
      acc = -1;
      for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], (i == 0) && last, acc);
      exp_q.push_back('{w, 4'hF, last, timed ? acc : -1});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish required finish within 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_out_data", bus.out_data, 0);
      chk("reset_out_keep", 32'(bus.out_keep), 0);
      chk("reset_out_last", 32'(bus.out_last), 0);
      chk("reset_read_req", 32'(bus.read_req), 0);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", 32'(bus.out_valid), 0);

      // continuous stream and signed passthrough
      send_word(32'h01020304, 1'b0, 1'b1);
      send_word(32'h05060708, 1'b0, 1'b1);
      send_word(32'h80FF7F00, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // backpressure with a second word offered during the stall
      bus.out_ready = 1'b0;
      send_word(32'h21222324, 1'b0, 1'b0);
      fork
         send_word(32'h31323334, 1'b0, 1'b0);
         begin
            repeat (6) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(bus.in_ready), 0);
               chk("stall_out_valid", 32'(bus.out_valid), 1);
               chk("stall_out_data", bus.out_data, 32'h21222324);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // partial flush after two samples
      send(8'h11, 1'b0, acc);
      send(8'h22, 1'b1, acc);
      exp_q.push_back('{32'h11220000, 4'b1100, 1'b1, acc});
      // flush on the very first sample
      send(8'hAA, 1'b1, acc);
      exp_q.push_back('{32'hAA000000, 4'b1000, 1'b1, acc});
      // in_last on a full word
      send_word(32'h41424344, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // reset in the middle of a word
      send(8'h51, 1'b0, acc);
      send(8'h52, 1'b0, acc);
      send(8'h53, 1'b0, acc);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(bus.out_valid), 0);
      chk("midreset_out_data", bus.out_data, 0);
      chk("midreset_out_keep", 32'(bus.out_keep), 0);
      chk("midreset_out_last", 32'(bus.out_last), 0);
      chk("midreset_read_req", 32'(bus.read_req), 0);
      tb_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_word(32'h61626364, 1'b0, 1'b1);

      repeat (5) @(posedge clk);
      #1;
      chk("words_outstanding", exp_q.size(), 0);
      chk("read_req_outstanding", rr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq2par_packer.md
Name: seq2par_packer

Overview:
- Parametrised serial-to-parallel packer for the accelerator input path.
- Collects DATA_W-bit signed samples from a serial stream into LANES-wide parallel words, with the oldest sample in the MSB lane, and feeds the PE array.
- Replaces the fixed 8-bit/4-lane packer. Adds:
  - ready/valid backpressure on both sides;
  - end-of-stream flush of partial words with a lane-keep mask;
  - a configurable prefetch-request pulse.

Parameters:
- DATA_W, 8, sample width in bits (signed two's complement).
- LANES, 4, samples per output word (must be ≥2).
- REQ_AT, 2, sample index within a word (1..LANES) whose acceptance triggers read_req.
- PAD_VAL, 0, value driven into unfilled lanes on a partial flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  serial sample.
- in_valid  in  1  in_data valid.
- in_last  in  1  sample is final in stream; qualified by in_valid.
- in_ready  out  1  packer can accept a sample this cycle.
- out_data  out  LANES*DATA_W  packed word; lane LANES-1 (MSB) = first sample.
- out_keep  out  LANES  per-lane valid mask; bit i qualifies lane i.
- out_last  out  1  word closes the stream.
- out_valid  out  1  out_data/out_keep/out_last valid.
- out_ready  in  1  consumer accepts the word.
- read_req  out  1  one-cycle prefetch pulse to the upstream buffer.

Behaviour:
- Reset (async, rst_n=0): fill count=0, shift register cleared to 0, out_valid=0, out_data=0, out_keep=0, out_last=0, read_req=0. A partial word in flight is discarded. No output pulse on reset release.
- Accept rule: sample accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational.
  - No combinational path from in_valid to in_ready.
- Accumulation:
  - On accept, the sample shifts into the LSB side of the LANES-deep register.
  - Fill count increments 0..LANES-1.
  - No state change without accept.
- Word completion: the accept is the closing accept when count==LANES-1 or in_last=1.
  - Next edge: output register loads; out_valid=1; count returns to 0. Latency is 1 cycle from the closing accept.
  - Full word: out_keep = all ones; out_last = in_last of the closing sample.
  - Partial word (k samples, k<LANES, in_last=1): samples left-aligned into lanes LANES-1..LANES-k in arrival order; remaining lanes = PAD_VAL; out_keep has the top k bits set; out_last=1.
  - in_last with count==LANES-1 gives a full word with out_last=1, not an extra empty word.
- Output handshake:
  - out_valid holds, and out_data/out_keep/out_last stay stable, until out_valid && out_ready.
  - out_valid clears on that transfer unless a new word is loaded on the same edge. Back-to-back words run at full rate.
- Stall: while out_valid && !out_ready, in_ready=0 and the accumulator is frozen, including partial fill.
- read_req: registered one-cycle pulse the edge after accepting the REQ_AT-th sample of a word (count goes REQ_AT-1→REQ_AT).
  - Not asserted for a word closed by in_last before reaching REQ_AT.
  - Never asserted on consecutive cycles for the same word.
- Widths: count width = clog2(LANES). Samples pass through without sign change; no arithmetic on data.
- Illegal parameters (REQ_AT outside 1..LANES, LANES<2) fail elaboration.

Decomposition:
- Shared package accel_pkg: clog2 function, default DATA_W/LANES constants, lane-index typedef.
- One natural sub-module: seq2par_out_stage. It is the output holding register with valid/ready, load and hold logic, instantiated once.
- Accumulator, counter and read_req stay in the top module.

Test Plan:
- Continuous stream, LANES=4, DATA_W=8, out_ready=1: inputs 0x01,0x02,0x03,0x04,0x05..0x08.
  - out_data=0x01020304, then 0x05060708, each 1 cycle after the 4th accept.
  - out_keep=4'b1111; read_req pulses the cycle after each 2nd accept.
- Signed passthrough: inputs 0x80,0xFF,0x7F,0x00 → out_data=0x80FF7F00, no sign extension or corruption.
- Backpressure: hold out_ready=0 with one word pending and 4 more samples offered.
  - in_ready=0; out_data stays stable; no samples lost.
  - Release: first word transfers and the next 4 are packed correctly.
- Partial flush: 0x11,0x22 (in_last on 0x22) → out_data=0x11220000, out_keep=4'b1100, out_last=1. read_req fires once after 0x22.
- Edge flush: in_last on 1st sample 0xAA → out_data=0xAA000000, out_keep=4'b1000, no read_req.
  - in_last on 4th sample → keep=4'b1111, last=1, no trailing word.
- Reset mid-word: accept 3 samples, pulse rst_n low asynchronously → all outputs 0 immediately; next 4 samples form a clean word with no residue.
